// File: rtl/fifo_pkg.sv
// fifo_pkg: defaults and Gray/binary pointer helpers shared by both FIFO sides.
// The helpers take the pointer width as an argument and mask to it.
package fifo_pkg;

   localparam int DEF_DATASIZE = 8;
   localparam int DEF_ADDRSIZE = 4;
   localparam int PTR_MAXW     = 32;

   typedef logic [PTR_MAXW-1:0] ptr_t;

   function automatic ptr_t width_mask(input int w);
      ptr_t m;
      if (w >= PTR_MAXW) m = '1;
      else               m = (ptr_t'(1) << w) - ptr_t'(1);
      return m;
   endfunction

   function automatic ptr_t bin2gray(input ptr_t b, input int w);
      ptr_t v;
      v = b & width_mask(w);
      return v ^ (v >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g, input int w);
      ptr_t v;
      ptr_t b;
      v = g & width_mask(w);
      b = v;
      for (int i = 1; i < PTR_MAXW; i++) begin
         b = b ^ (v >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_outstage.sv
// fifo_rd_outstage: one-entry valid/ready output register for FWFT readers.
// A load always wins; an accept without a load empties the stage.
module fifo_rd_outstage import fifo_pkg::*; #(
   parameter int DATASIZE = DEF_DATASIZE
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic                load,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                rready,
   output logic                rvalid,
   output logic [DATASIZE-1:0] rdata
);

   logic                rvalid_q;
   logic                rvalid_d;
   logic [DATASIZE-1:0] rdata_q;
   logic [DATASIZE-1:0] rdata_d;

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (load) begin
         rvalid_d = 1'b1;
         rdata_d  = data_in;
      end else if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read side -- pointers, empty flag, FWFT output.
// FIFO_RD_AEMPTY_EN adds the registered ralmost_empty output.
module fifo_rd_ctrl import fifo_pkg::*; #(
   parameter int DATASIZE      = DEF_DATASIZE,
   parameter int ADDRSIZE      = DEF_ADDRSIZE,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   input  logic [DATASIZE-1:0] mem_rdata,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                rvalid,
   input  logic                rready,
`ifdef FIFO_RD_AEMPTY_EN
   output logic                ralmost_empty,
`endif
   output logic [DATASIZE-1:0] rdata
);

   localparam int PW = ADDRSIZE + 1;

   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDRSIZE)) begin : g_bad_thresh
      $error("fifo_rd_ctrl: AEMPTY_THRESH out of range");
   end

   logic [ADDRSIZE:0] rbin_q;
   logic [ADDRSIZE:0] rbin_d;
   logic [ADDRSIZE:0] rptr_q;
   logic [ADDRSIZE:0] rptr_d;
   logic              rempty_q;
   logic              rempty_d;
   logic              fetch;

   // Refill the output stage whenever it is free or being drained this cycle.
   always_comb begin
      fetch    = !rempty_q && (!rvalid || rready);
      rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
      rptr_d   = PW'(bin2gray(ptr_t'(rbin_d), PW));
      rempty_d = (rptr_d == rq2_wptr);
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin_q   <= '0;
         rptr_q   <= '0;
         rempty_q <= 1'b1;
      end else begin
         rbin_q   <= rbin_d;
         rptr_q   <= rptr_d;
         rempty_q <= rempty_d;
      end
   end

`ifdef FIFO_RD_AEMPTY_EN
   logic [ADDRSIZE:0] wbin_s;
   logic [ADDRSIZE:0] rcount;
   logic              ralmost_empty_q;
   logic              ralmost_empty_d;

   // Words left in memory after this edge's fetch, modulo pointer range.
   always_comb begin
      wbin_s          = PW'(gray2bin(ptr_t'(rq2_wptr), PW));
      rcount          = wbin_s - rbin_d;
      ralmost_empty_d = (ptr_t'(rcount) <= ptr_t'(AEMPTY_THRESH));
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         ralmost_empty_q <= 1'b1;
      end else begin
         ralmost_empty_q <= ralmost_empty_d;
      end
   end

   assign ralmost_empty = ralmost_empty_q;
`endif

   fifo_rd_outstage #(
      .DATASIZE (DATASIZE)
   ) u_outstage (
      .rclk    (rclk),
      .rrst    (rrst),
      .load    (fetch),
      .data_in (mem_rdata),
      .rready  (rready),
      .rvalid  (rvalid),
      .rdata   (rdata)
   );

   assign raddr  = rbin_q[ADDRSIZE-1:0];
   assign rptr   = rptr_q;
   assign rempty = rempty_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and random checks of the FIFO read controller.
// A writer model fills a memory array; a monitor checks words in write order.
module tb_fifo_rd_ctrl;

   localparam int DW     = 8;
   localparam int AW     = 4;
   localparam int DEPTH  = 16;
   localparam int THRESH = 2;

   logic          rclk = 1'b0;
   logic          rrst;
   logic [AW:0]   rq2_wptr;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] raddr;
   logic [AW:0]   rptr;
   logic          rempty;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;
`ifdef FIFO_RD_AEMPTY_EN
   logic          ralmost_empty;
`endif

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   int            wcount;
   int            n_acc;
   int            n_cmp;
   int            n_bad;

   fifo_rd_ctrl #(
      .DATASIZE      (DW),
      .ADDRSIZE      (AW),
      .AEMPTY_THRESH (THRESH)
   ) dut (
      .rclk          (rclk),
      .rrst          (rrst),
      .rq2_wptr      (rq2_wptr),
      .mem_rdata     (mem_rdata),
      .raddr         (raddr),
      .rptr          (rptr),
      .rempty        (rempty),
      .rvalid        (rvalid),
      .rready        (rready),
`ifdef FIFO_RD_AEMPTY_EN
      .ralmost_empty (ralmost_empty),
`endif
      .rdata         (rdata)
   );

   always #5 rclk = ~rclk;

   assign mem_rdata = mem[raddr];

   function automatic logic [AW:0] gray_of(input int n);
      logic [AW:0] b;
      b = n[AW:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      mem[wcount % DEPTH] = d;
      exp_q.push_back(d);
      wcount++;
      rq2_wptr = gray_of(wcount);
   endtask

   task automatic do_reset();
      @(posedge rclk);
      #1;
      rrst     = 1'b1;
      rready   = 1'b0;
      wcount   = 0;
      n_acc    = 0;
      rq2_wptr = '0;
      exp_q.delete();
      @(posedge rclk);
      #1;
      rrst = 1'b0;
   endtask

   // Monitor: a handshake seen here completes at the next rising edge.
   always @(negedge rclk) begin
      logic [DW-1:0] e;
      if (rrst === 1'b0 && rvalid === 1'b1 && rready === 1'b1) begin
         n_cmp++;
         n_acc++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_extra: got %0h expected no word", rdata);
         end else begin
            e = exp_q.pop_front();
            if (rdata !== e) begin
               n_bad++;
               $display("FAIL sb_data: got %0h expected %0h", rdata, e);
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] bp [3];
      n_cmp    = 0;
      n_bad    = 0;
      wcount   = 0;
      n_acc    = 0;
      rrst     = 1'b1;
      rready   = 1'b0;
      rq2_wptr = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      repeat (2) @(posedge rclk);
      #1;
      rrst = 1'b0;

      @(negedge rclk);
      chk("rst_rempty", 32'(rempty), 32'd1);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rptr", 32'(rptr), 32'd0);
      chk("rst_raddr", 32'(raddr), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
`ifdef FIFO_RD_AEMPTY_EN
      chk("rst_aempty", 32'(ralmost_empty), 32'd1);
`endif

      // Single word
      @(posedge rclk);
      #1;
      rready = 1'b1;
      write_word(8'hA5);
      @(negedge rclk);
      chk("sw_empty_n", 32'(rempty), 32'd1);
      @(negedge rclk);
      chk("sw_empty_n1", 32'(rempty), 32'd0);
      chk("sw_valid_n1", 32'(rvalid), 32'd0);
      @(negedge rclk);
      chk("sw_valid_n2", 32'(rvalid), 32'd1);
      chk("sw_data_n2", 32'(rdata), 32'hA5);
      chk("sw_empty_n2", 32'(rempty), 32'd1);
      @(negedge rclk);
      chk("sw_valid_n3", 32'(rvalid), 32'd0);

      // Backpressure
      do_reset();
      bp[0] = 8'h11;
      bp[1] = 8'h22;
      bp[2] = 8'h33;
      for (int i = 0; i < 3; i++) write_word(bp[i]);
      repeat (2) @(negedge rclk);
      for (int i = 0; i < 5; i++) begin
         @(negedge rclk);
         chk("bp_hold_valid", 32'(rvalid), 32'd1);
         chk("bp_hold_data", 32'(rdata), 32'h11);
         chk("bp_hold_raddr", 32'(raddr), 32'd1);
      end
      @(posedge rclk);
      #1;
      rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge rclk);
         chk("bp_burst_valid", 32'(rvalid), 32'd1);
         chk("bp_burst_data", 32'(rdata), 32'(bp[i]));
      end
      @(negedge rclk);
      chk("bp_end_valid", 32'(rvalid), 32'd0);
      chk("bp_end_empty", 32'(rempty), 32'd1);

      // Full drain and wrap
      do_reset();
      for (int i = 0; i < DEPTH; i++) write_word(8'($urandom));
      rready = 1'b1;
      repeat (2) @(negedge rclk);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge rclk);
         chk("fd_rate", 32'(rvalid), 32'd1);
         if (i == DEPTH - 1) chk("fd_last_empty", 32'(rempty), 32'd1);
      end
      @(negedge rclk);
      chk("fd_valid", 32'(rvalid), 32'd0);
      chk("fd_empty", 32'(rempty), 32'd1);
      chk("fd_rptr", 32'(rptr), 32'b11000);
      chk("fd_raddr", 32'(raddr), 32'd0);
      chk("fd_sb_empty", 32'(exp_q.size()), 32'd0);

      // Reset mid-stream
      do_reset();
      for (int i = 0; i < 4; i++) write_word(8'($urandom));
      repeat (3) @(negedge rclk);
      chk("mr_valid_pre", 32'(rvalid), 32'd1);
      #1;
      rrst     = 1'b1;
      wcount   = 0;
      n_acc    = 0;
      rq2_wptr = '0;
      exp_q.delete();
      #1;
      chk("mr_valid", 32'(rvalid), 32'd0);
      chk("mr_empty", 32'(rempty), 32'd1);
      chk("mr_rptr", 32'(rptr), 32'd0);
      chk("mr_raddr", 32'(raddr), 32'd0);
      @(posedge rclk);
      #1;
      rrst   = 1'b0;
      rready = 1'b1;
      write_word(8'h5A);
      repeat (2) @(negedge rclk);
      @(negedge rclk);
      chk("mr_after_valid", 32'(rvalid), 32'd1);
      chk("mr_after_data", 32'(rdata), 32'h5A);

`ifdef FIFO_RD_AEMPTY_EN
      // Almost-empty: memory count after each edge vs threshold
      do_reset();
      for (int i = 0; i < 5; i++) write_word(8'($urandom));
      repeat (3) @(negedge rclk);
      chk("ae_settle", 32'(ralmost_empty), 32'd0);
      @(posedge rclk);
      #1;
      rready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge rclk);
         chk("ae_step", 32'(ralmost_empty), 32'((4 - k) <= THRESH));
      end
      repeat (3) @(negedge rclk);
`endif

      // Concurrent write at full read rate
      do_reset();
      rready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         write_word(8'($urandom));
         @(negedge rclk);
         if (i >= 1) chk("cw_never_empty", 32'(rempty), 32'd0);
         @(posedge rclk);
         #1;
      end
      repeat (6) @(negedge rclk);
      chk("cw_end_empty", 32'(rempty), 32'd1);
      chk("cw_sb_empty", 32'(exp_q.size()), 32'd0);

      // Random traffic with random backpressure
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1 && (wcount - n_acc) < DEPTH)
            write_word(8'($urandom));
         @(posedge rclk);
         #1;
      end
      rready = 1'b1;
      repeat (24) @(negedge rclk);
      chk("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("rnd_end_empty", 32'(rempty), 32'd1);
      chk("rnd_end_valid", 32'(rvalid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the async FIFO. It owns the read-domain pointer logic and drives the read address into the shared dual-port memory. It also generates the registered empty flag and presents words through a one-entry valid/ready output stage (first-word-fall-through). It receives the write pointer already synchronized into the read domain and returns its own Gray pointer for synchronization into the write domain.

## Interface
Parameters:
- DATASIZE, 8, data word width
- ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE
- AEMPTY_THRESH, 2, almost-empty threshold in words; used only with FIFO_RD_AEMPTY_EN

Ports:
- rclk  in  1  read-domain clock; the only clock
- rrst  in  1  asynchronous, active-high reset
- rq2_wptr  in  ADDRSIZE+1  Gray write pointer, already 2-flop synchronized to rclk
- mem_rdata  in  DATASIZE  combinational memory read data at raddr
- raddr  out  ADDRSIZE  memory read address
- rptr  out  ADDRSIZE+1  registered Gray read pointer, to the write-domain synchronizer
- rempty  out  1  registered memory-empty flag; excludes the output register
- rvalid  out  1  output word valid
- rready  in  1  consumer accepts rdata when rvalid && rready
- rdata  out  DATASIZE  output word, registered
- ralmost_empty  out  1  registered; present only with FIFO_RD_AEMPTY_EN

## Operation
- Internal binary pointer rbin, ADDRSIZE+1 bits. raddr = rbin[ADDRSIZE-1:0]. rptr = bin2gray(rbin), registered with rbin.
- fetch = !rempty && (!rvalid || rready). This is the only increment condition.
- On fetch: rdata <= mem_rdata, rvalid <= 1, rbin <= rbin + 1.
- When rvalid && rready && !fetch: rvalid <= 0. rdata holds its value.
- When !rready && rvalid: rdata, rvalid and rbin all hold.
- rbinnext = rbin + fetch; rgraynext = bin2gray(rbinnext). rempty <= (rgraynext == rq2_wptr).
- Arithmetic is modulo 2^(ADDRSIZE+1). The MSB distinguishes full from empty.
- Wrap: after 2^ADDRSIZE fetches, raddr returns to 0 and the rptr MSB toggles.
- Full memory: rq2_wptr = bin2gray(2^ADDRSIZE) with rbin = 0 is not empty. Exactly 2^ADDRSIZE fetches drain it.
- Simultaneous accept and fetch: the next word replaces rdata in the same edge and rvalid stays 1. This sustains 1 word/cycle.
- rq2_wptr advancing while rempty = 1: the flag clears on the following edge. No word is fetched until then.
- Reset: rbin = 0, rptr = 0, raddr = 0, rempty = 1, rvalid = 0, rdata = 0, ralmost_empty = 1.
- Reset asserted mid-operation clears all state immediately; a word in the output stage is discarded.
- Reset release must be synchronous to rclk; the integrator provides this.

## Timing
- rq2_wptr changes from empty at edge N: rempty falls at N+1; rdata/rvalid valid after N+2.
- Steady state: one word per cycle while rready = 1 and the memory is non-empty.
- Last word read: rempty rises at the same edge that loads that word into rdata.
- rempty can deassert only one cycle after rq2_wptr changes. It asserts in the same cycle as the draining fetch.
- No combinational path from rready to any output.

## Configuration
- FIFO_RD_AEMPTY_EN defined: adds port ralmost_empty.
  - ralmost_empty <= ((gray2bin(rq2_wptr) - rbinnext) <= AEMPTY_THRESH).
  - Reset value 1.
- FIFO_RD_AEMPTY_EN undefined: the port and its logic are absent, and AEMPTY_THRESH is unused.

## Structure
- Package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized by width
  - default DATASIZE and ADDRSIZE localparams, shared with the write-side modules
- Sub-module fifo_rd_outstage holds the one-entry valid/ready output register.
  - Inputs: load, data_in, rready.
  - Outputs: rvalid, rdata.
  - It is reused by any later FWFT reader.

## Test plan
- Reset: assert rrst mid-stream with rvalid = 1 -> rvalid = 0, rempty = 1, rptr = 0 at once; next read after release comes from address 0.
- Single word: rq2_wptr 00000 -> 00001 at edge N, rready = 1, memory[0] = 0xA5 -> rempty = 0 at N+1; rdata = 0xA5, rvalid = 1 after N+2; rempty = 1 after N+2.
- Backpressure: 3 words 0x11, 0x22, 0x33, rready = 0 for 5 cycles, then 1 -> rdata holds 0x11, raddr holds 1; then 0x11, 0x22, 0x33 on consecutive cycles.
- Full drain and wrap: rq2_wptr = 11000, rready = 1 -> 16 words in order at 1/cycle; rptr ends at 11000; raddr wraps to 0; rempty = 1.
- Almost-empty (macro on, THRESH = 2): 5 words queued, consume one per cycle -> ralmost_empty = 0 until the remaining count reaches 2, then 1.
- Concurrent write: rq2_wptr advances every cycle while reading at full rate -> rempty never asserts; no word is lost or duplicated (scoreboard).
